// File: rtl/seg7_sniffer.sv
// seg7_sniffer: receive-side monitor for a multiplexed 7-segment display.
// It watches the active-low anode and segment lines, filters out short
// glitches, decodes each stable digit back to a hex nibble and publishes
// the full 8-digit word once every digit has been freshly seen.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   an[7:0]             digit anodes, active-low (an[i]=0 selects digit i)
//   ca..cg, dp          segments a..g and decimal point, active-low
//   value[31:0]         last complete word, digit i at value[4i+3:4i]
//   dp_mask[7:0]        decimal point per digit captured with value, 1 = lit
//   valid               one-cycle pulse when value/dp_mask update
//   changed             with valid: new word/dp differs from previous one
//   pattern_err         one-cycle pulse on a committed unknown segment pattern
//   an_err              one-cycle pulse on a committed multi-digit anode word
module seg7_sniffer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic        ca,
  input  logic        cb,
  input  logic        cc,
  input  logic        cd,
  input  logic        ce,
  input  logic        cf,
  input  logic        cg,
  input  logic        dp,
  output logic [31:0] value,
  output logic [7:0]  dp_mask,
  output logic        valid,
  output logic        changed,
  output logic        pattern_err,
  output logic        an_err
);

  // Segment pattern {g..a} (active-high) to {recognised, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Input capture stage (inverted to active-high) and dwell tracking state.
  logic [7:0]       an_q, hold_an_q, hold_an_d;
  logic [6:0]       seg_q, hold_seg_q, hold_seg_d;
  logic             dpl_q, hold_dp_q, hold_dp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             committed_q, committed_d;

  // Frame assembly and published outputs.
  logic [31:0] digit_q, digit_d;
  logic [7:0]  dpr_q, dpr_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  dp_mask_q, dp_mask_d;
  logic        valid_q, valid_d;
  logic        changed_q, changed_d;
  logic        perr_q, perr_d;
  logic        aerr_q, aerr_d;

  logic        commit_s;
  logic [7:0]  an_low_s;
  logic        one_hot_s;
  logic [2:0]  idx_s;
  logic [4:0]  dec_s;

  // Register the raw display lines once before any use.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 8'h00;
      seg_q <= 7'h00;
      dpl_q <= 1'b0;
    end else begin
      an_q  <= an;
      seg_q <= ~{cg, cf, ce, cd, cc, cb, ca};
      dpl_q <= ~dp;
    end
  end

  // Dwell counter: restart on any change, otherwise count up and saturate.
  always_comb begin
    hold_an_d   = hold_an_q;
    hold_seg_d  = hold_seg_q;
    hold_dp_d   = hold_dp_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    commit_s    = (cnt_q == STABLE_C) && !committed_q;
    if ({an_q, seg_q, dpl_q} != {hold_an_q, hold_seg_q, hold_dp_q}) begin
      hold_an_d   = an_q;
      hold_seg_d  = seg_q;
      hold_dp_d   = dpl_q;
      cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
      committed_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      if (commit_s) begin
        committed_d = 1'b1;
      end else begin
        committed_d = committed_q;
      end
    end
  end

  // Anode classification of the held pattern: selected digit index, one-hot check.
  always_comb begin
    an_low_s  = ~hold_an_q;
    one_hot_s = (an_low_s != 8'h00) && ((an_low_s & (an_low_s - 8'h01)) == 8'h00);
    dec_s     = seg_decode(hold_seg_q);
    idx_s     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low_s[i]) begin
        idx_s = i[2:0];
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // Commit and publish: a publish clears seen first so a same-cycle commit
  // counts toward the next frame.
  always_comb begin
    digit_d   = digit_q;
    dpr_d     = dpr_q;
    value_d   = value_q;
    dp_mask_d = dp_mask_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    perr_d    = 1'b0;
    aerr_d    = 1'b0;
    if (seen_q == 8'hFF) begin
      value_d   = digit_q;
      dp_mask_d = dpr_q;
      valid_d   = 1'b1;
      changed_d = (digit_q != value_q) || (dpr_q != dp_mask_q);
      seen_d    = 8'h00;
    end else begin
      seen_d    = seen_q;
    end
    if (commit_s && (an_low_s != 8'h00)) begin
      if (one_hot_s) begin
        if (dec_s[4]) begin
          digit_d[4*idx_s +: 4] = dec_s[3:0];
          dpr_d[idx_s]          = hold_dp_q;
          seen_d[idx_s]         = 1'b1;
        end else begin
          perr_d        = 1'b1;
          seen_d[idx_s] = 1'b0;
        end
      end else begin
        aerr_d = 1'b1;
      end
    end else begin
      aerr_d = 1'b0;
    end
  end

  // State registers for dwell tracking, frame assembly and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_an_q   <= 8'h00;
      hold_seg_q  <= 7'h00;
      hold_dp_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      committed_q <= 1'b0;
      digit_q     <= 32'h0000_0000;
      dpr_q       <= 8'h00;
      seen_q      <= 8'h00;
      value_q     <= 32'h0000_0000;
      dp_mask_q   <= 8'h00;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      perr_q      <= 1'b0;
      aerr_q      <= 1'b0;
    end else begin
      hold_an_q   <= hold_an_d;
      hold_seg_q  <= hold_seg_d;
      hold_dp_q   <= hold_dp_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      digit_q     <= digit_d;
      dpr_q       <= dpr_d;
      seen_q      <= seen_d;
      value_q     <= value_d;
      dp_mask_q   <= dp_mask_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      perr_q      <= perr_d;
      aerr_q      <= aerr_d;
    end
  end

  assign value       = value_q;
  assign dp_mask     = dp_mask_q;
  assign valid       = valid_q;
  assign changed     = changed_q;
  assign pattern_err = perr_q;
  assign an_err      = aerr_q;

endmodule

// File: tb/tb_seg7_sniffer.sv
// Directed bench for seg7_sniffer: scans words onto the display lines and
// checks published words, change flags and error pulses.
module tb_seg7_sniffer;

  logic        clk;
  logic        rst;
  logic [7:0]  an;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        valid, changed, pattern_err, an_err;

  int nvec;
  int nmis;

  // Pulse monitors (bench-side counters, not reset by DUT reset).
  int          valid_cnt;
  int          perr_cnt;
  int          aerr_cnt;
  logic [31:0] last_value;
  logic [7:0]  last_dp;
  logic        last_changed;

  seg7_sniffer #(.STABLE_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .an(an),
    .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp),
    .value(value), .dp_mask(dp_mask), .valid(valid), .changed(changed),
    .pattern_err(pattern_err), .an_err(an_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt    = valid_cnt + 1;
      last_value   = value;
      last_dp      = dp_mask;
      last_changed = changed;
    end
    if (pattern_err) perr_cnt = perr_cnt + 1;
    if (an_err) aerr_cnt = aerr_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec = nvec + 1;
    if (obs !== exp) begin
      nmis = nmis + 1;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; 4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Drive an arbitrary anode word and segment pattern for cyc cycles.
  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic lit, input int cyc);
    @(posedge clk);
    #1;
    an = a;
    {cg, cf, ce, cd, cc, cb, ca} = ~s;
    dp = ~lit;
    repeat (cyc) @(posedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] s, input logic lit, input int cyc);
    logic [7:0] a;
    a = ~(8'h01 << d);
    drive(a, s, lit, cyc);
  endtask

  task automatic scan(input logic [31:0] w, input logic [7:0] m, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) begin
      show(d, seg_of(w[4*d +: 4]), m[d], 20);
    end
  endtask

  task automatic blank_idle(input int cyc);
    drive(8'hFF, 7'h00, 1'b0, cyc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    an = 8'hFF;
    {cg, cf, ce, cd, cc, cb, ca} = 7'h7F;
    dp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] w_dead;
  logic [31:0] w_1234;

  initial begin
    nvec = 0; nmis = 0;
    valid_cnt = 0; perr_cnt = 0; aerr_cnt = 0;
    last_value = 32'h0; last_dp = 8'h0; last_changed = 1'b0;
    rst = 1'b1;
    an = 8'hFF;
    {cg, cf, ce, cd, cc, cb, ca} = 7'h7F;
    dp = 1'b1;
    w_dead = 32'hDEAD_BEEF;
    w_1234 = 32'h1234_5678;
    do_reset();
    @(negedge clk);

    // Reset state
    check_vec("rst_value", value, 32'h0);
    check_vec("rst_dp_mask", {24'h0, dp_mask}, 32'h0);
    check_vec("rst_valid", {31'h0, valid}, 32'h0);
    check_vec("rst_changed", {31'h0, changed}, 32'h0);
    check_vec("rst_perr", {31'h0, pattern_err}, 32'h0);
    check_vec("rst_aerr", {31'h0, an_err}, 32'h0);

    // Frame 1: DEADBEEF, no dp
    blank_idle(20);
    scan(w_dead, 8'h00, 0, 7);
    show(7, seg_of(w_dead[31:28]), 1'b0, 4);
    check_vec("f1_count", valid_cnt, 32'd1);
    check_vec("f1_value", last_value, 32'hDEAD_BEEF);
    check_vec("f1_dp", {24'h0, last_dp}, 32'h0);
    check_vec("f1_changed", {31'h0, last_changed}, 32'h1);
    check_vec("f1_value_out", value, 32'hDEAD_BEEF);

    // Frame 2: same word, 5-cycle glitch (s=06) on digit 3
    scan(w_dead, 8'h00, 0, 2);
    show(3, 7'h06, 1'b0, 5);
    scan(w_dead, 8'h00, 3, 7);
    show(7, seg_of(w_dead[31:28]), 1'b0, 4);
    check_vec("f2_count", valid_cnt, 32'd2);
    check_vec("f2_changed", {31'h0, last_changed}, 32'h0);
    check_vec("f2_value", last_value, 32'hDEAD_BEEF);
    check_vec("f2_no_perr", perr_cnt, 32'd0);

    // Frame 3: blank pattern on digit 2 is an error, then a proper recommit
    scan(w_dead, 8'h00, 0, 1);
    show(2, 7'h00, 1'b0, 20);
    scan(w_dead, 8'h00, 3, 7);
    show(7, seg_of(w_dead[31:28]), 1'b0, 4);
    check_vec("f3_perr", perr_cnt, 32'd1);
    check_vec("f3_no_valid", valid_cnt, 32'd2);
    scan(w_dead, 8'h00, 2, 2);
    show(2, seg_of(w_dead[11:8]), 1'b0, 4);
    check_vec("f3_count", valid_cnt, 32'd3);
    check_vec("f3_value", last_value, 32'hDEAD_BEEF);

    // Frame 4: two anodes low mid-frame leaves seen intact
    scan(w_dead, 8'h00, 0, 6);
    drive(8'hFC, seg_of(4'h8), 1'b0, 20);
    check_vec("f4_aerr", aerr_cnt, 32'd1);
    check_vec("f4_no_valid", valid_cnt, 32'd3);
    scan(w_dead, 8'h00, 7, 7);
    show(7, seg_of(w_dead[31:28]), 1'b0, 4);
    check_vec("f4_count", valid_cnt, 32'd4);
    check_vec("f4_value", last_value, 32'hDEAD_BEEF);
    check_vec("f4_perr_total", perr_cnt, 32'd1);

    // Reset mid-frame discards partial digits
    scan(w_1234, 8'h00, 0, 4);
    do_reset();
    @(negedge clk);
    check_vec("r_value", value, 32'h0);
    scan(w_1234, 8'h00, 5, 7);
    show(7, seg_of(w_1234[31:28]), 1'b0, 4);
    check_vec("r_no_valid", valid_cnt, 32'd4);
    scan(w_1234, 8'h00, 0, 7);
    show(7, seg_of(w_1234[31:28]), 1'b0, 4);
    check_vec("r_count", valid_cnt, 32'd5);
    check_vec("r_value2", last_value, 32'h1234_5678);
    check_vec("r_changed", {31'h0, last_changed}, 32'h1);

    // Decimal points on digits 0 and 7 over an all-zero word
    do_reset();
    scan(32'h0, 8'h81, 0, 7);
    show(7, seg_of(4'h0), 1'b1, 4);
    check_vec("dp_count", valid_cnt, 32'd6);
    check_vec("dp_mask", {24'h0, last_dp}, 32'h81);
    check_vec("dp_value", last_value, 32'h0);
    check_vec("dp_changed", {31'h0, last_changed}, 32'h1);
    check_vec("final_aerr_total", aerr_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/seg7_sniffer.md
Name: seg7_sniffer

Overview:
- Receive-side counterpart of the 7-segment multiplexed display driver.
- Watches the active-low, time-multiplexed AN and CA..CG/DP lines, decodes each digit's segment pattern back to a hex nibble, and reassembles the full displayed word.
- Used for on-board loopback self-check and as a bench monitor for the display path.
- One clock domain, the same clock as the display driver.

Parameters:
- STABLE_CYCLES, 16: a digit pattern must be held unchanged for this many consecutive cycles before it is committed (glitch filter); legal range 1..65535.
- CNT_W, 16: width of the dwell counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- an  in  8  digit anodes, active-low; an[i]=0 selects digit i.
- ca, cb, cc, cd, ce, cf, cg  in  1 each  segments a..g, active-low.
- dp  in  1  decimal point, active-low.
- value  out  32  last complete word; digit i maps to value[4i+3:4i].
- dp_mask  out  8  decimal point state per digit, captured with value; 1 = lit.
- valid  out  1  one-cycle pulse when value/dp_mask update.
- changed  out  1  qualifies valid; 1 if the new value differs from the previous published value.
- pattern_err  out  1  one-cycle pulse on a committed unrecognised segment pattern.
- an_err  out  1  one-cycle pulse on a committed anode word with more than one low bit.

Behaviour:
- Reset values: value=0, dp_mask=0, valid=0, changed=0, pattern_err=0, an_err=0, seen=0, digit/dp regs=0, dwell counter=0, committed flag=0.
- All inputs are registered once before use, adding 1 cycle of latency.
- Segment vector: s[6:0] = ~{cg,cf,ce,cd,cc,cb,ca}, i.e. active-high {g..a}.
- Decode table for s (hex):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7
  - 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F
  - any other pattern is unrecognised.
- Dwell tracking on the registered {an, s, dp}:
  - Any change: counter=1, committed=0.
  - No change: counter increments, saturating at all-ones.
- Commit occurs when counter==STABLE_CYCLES and committed==0; committed is then set, so each dwell commits at most once.
- Commit actions by anode state:
  - an all ones (blanked): nothing happens.
  - Exactly one bit i low, pattern recognised: digit[i] and dp[i] are written, seen[i]=1.
  - Exactly one bit i low, pattern unrecognised: pattern_err pulses, seen[i]=0, digit[i] unchanged.
  - Two or more bits low: an_err pulses; seen and digits unchanged.
- Publish:
  - Condition: the cycle after seen reaches all ones.
  - value/dp_mask load the digit/dp regs, valid pulses for 1 cycle, and changed = (new value != old value) || (new dp_mask != old dp_mask).
  - seen clears in the same cycle, and a new frame starts.
  - A commit to digit i in that same cycle sets seen[i] after the clear.
- A digit re-committed before the frame completes overwrites the earlier nibble; the last commit wins.
- changed is meaningful only while valid=1 and is 0 otherwise.
- Total latency from a pattern change to commit: 1 + STABLE_CYCLES cycles.
- Reset mid-frame discards partial digits and seen. The first valid after reset requires all 8 digits to be freshly committed.
- The scan order of the driver is irrelevant; any order and repetition are accepted.

Test Plan:
- Drive digits 0..7 of 32'hDEADBEEF with all dp off, each held 20 cycles, then repeat the scan.
  - -> One valid with value=DEADBEEF, dp_mask=00, changed=1.
  - -> Second frame: valid with changed=0.
- Insert a 5-cycle wrong pattern (s=06) on digit 3 before its correct 20-cycle dwell.
  - -> No pattern_err.
  - -> value still DEADBEEF.
- Hold s=00 on digit 2 for 20 cycles.
  - -> pattern_err pulses once.
  - -> No valid until digit 2 is recommitted correctly.
- Hold an=8'b1111_1100 for 20 cycles.
  - -> an_err pulses once.
  - -> seen unchanged.
- Assert rst after digits 0..4 of 12345678 are committed, then scan only digits 5..7.
  - -> No valid.
  - -> A full rescan yields value=12345678.
- Light dp on digits 0 and 7 while scanning 0000_0000.
  - -> valid with dp_mask=81 and value=00000000.
  - -> changed=1 relative to the reset value.
